// File: rtl/dendrite_acc.sv
// Synapse-dendrite accumulator: Vm[addr] += sign_extend(W[wgt_addr]), one op per cycle, with RAW forwarding.
// Optional saturating add and sticky overflow flag when DENDRITE_SAT_EN is defined.
module dendrite_acc #(
    parameter int NNW = 12,
    parameter int WD  = 6,
    parameter int WW  = 8,
    parameter int VW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    // Valid-only handshake: axon_sd_vld marks one operation that must be taken
    // that cycle; there is no ready, so every stage advances every cycle.
    input  logic           axon_sd_vld,
    input  logic [NNW-1:0] axon_sd_vm_addr,
    input  logic [WD-1:0]  axon_sd_wgt_addr,
    output logic           sd_wgt_ren,
    output logic [WD-1:0]  sd_wgt_raddr,
    input  logic [WW-1:0]  sd_wgt_rdata,
    output logic           sd_vm_ren,
    output logic [NNW-1:0] sd_vm_raddr,
    input  logic [VW-1:0]  sd_vm_rdata,
    output logic           sd_vm_we,
    output logic [NNW-1:0] sd_vm_waddr,
    output logic [VW-1:0]  sd_vm_wdata,
    output logic           sd_busy,
    output logic           sd_sat_flag
);

    logic           p1_vld;
    logic [NNW-1:0] p1_addr;
    logic           wr_vld;
    logic [NNW-1:0] wr_addr;
    logic [VW-1:0]  wr_data;
    logic           wb2_vld;
    logic [NNW-1:0] wb2_addr;
    logic [VW-1:0]  wb2_data;

    logic [VW-1:0]  operand;
    logic [VW-1:0]  wgt_ext;
    logic [VW-1:0]  sum;

    assign sd_wgt_ren   = axon_sd_vld;
    assign sd_vm_ren    = axon_sd_vld;
    assign sd_wgt_raddr = axon_sd_wgt_addr;
    assign sd_vm_raddr  = axon_sd_vm_addr;

    // Newest in-flight result wins; WB2 covers the write that the memory
    // could not yet reflect when this operation's read was issued.
    always_comb begin
        operand = sd_vm_rdata;
        if (wr_vld && (wr_addr == p1_addr)) begin
            operand = wr_data;
        end else if (wb2_vld && (wb2_addr == p1_addr)) begin
            operand = wb2_data;
        end
    end

    assign wgt_ext = {{(VW-WW){sd_wgt_rdata[WW-1]}}, sd_wgt_rdata};

`ifdef DENDRITE_SAT_EN
    logic [VW:0] sum_ext;
    logic        sum_sat;
    logic        sat_q;

    assign sum_ext = {operand[VW-1], operand} + {wgt_ext[VW-1], wgt_ext};

    // Overflow shows up as disagreement between the guard bit and the sign bit.
    always_comb begin
        sum     = sum_ext[VW-1:0];
        sum_sat = 1'b0;
        if (sum_ext[VW] != sum_ext[VW-1]) begin
            sum_sat = 1'b1;
            sum     = sum_ext[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (p1_vld && sum_sat) begin
            sat_q <= 1'b1;
        end
    end

    assign sd_sat_flag = sat_q;
`else
    assign sum         = operand + wgt_ext;
    assign sd_sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_vld   <= 1'b0;
            p1_addr  <= '0;
            wr_vld   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wb2_vld  <= 1'b0;
            wb2_addr <= '0;
            wb2_data <= '0;
        end else begin
            p1_vld  <= axon_sd_vld;
            wr_vld  <= p1_vld;
            wb2_vld <= wr_vld;
            if (axon_sd_vld) begin
                p1_addr <= axon_sd_vm_addr;
            end
            if (p1_vld) begin
                wr_addr <= p1_addr;
                wr_data <= sum;
            end
            if (wr_vld) begin
                wb2_addr <= wr_addr;
                wb2_data <= wr_data;
            end
        end
    end

    assign sd_vm_we    = wr_vld;
    assign sd_vm_waddr = wr_addr;
    assign sd_vm_wdata = wr_data;

    // WB2 is excluded: its write has already landed in memory.
    assign sd_busy = axon_sd_vld | p1_vld | wr_vld;

endmodule

// File: tb/tb_dendrite_acc.sv
// Bench for dendrite_acc: memory models, directed cases from the test plan, then random ops
// checked against a sequential Vm/weight array model (honours DENDRITE_SAT_EN).
module tb_dendrite_acc;

    localparam int NNW  = 12;
    localparam int WD   = 6;
    localparam int WW   = 8;
    localparam int VW   = 16;
    localparam int VMAX = (1 << (VW-1)) - 1;
    localparam int VMIN = -(1 << (VW-1));

    typedef struct {
        logic [NNW-1:0] addr;
        logic [VW-1:0]  data;
        bit             sat;
        int             cyc;
    } wr_t;

    logic           clk;
    logic           rst;
    logic           axon_sd_vld;
    logic [NNW-1:0] axon_sd_vm_addr;
    logic [WD-1:0]  axon_sd_wgt_addr;
    logic           sd_wgt_ren;
    logic [WD-1:0]  sd_wgt_raddr;
    logic [WW-1:0]  sd_wgt_rdata;
    logic           sd_vm_ren;
    logic [NNW-1:0] sd_vm_raddr;
    logic [VW-1:0]  sd_vm_rdata;
    logic           sd_vm_we;
    logic [NNW-1:0] sd_vm_waddr;
    logic [VW-1:0]  sd_vm_wdata;
    logic           sd_busy;
    logic           sd_sat_flag;

    logic [VW-1:0]  vm_mem  [0:(1<<NNW)-1];
    logic [WW-1:0]  wgt_mem [0:(1<<WD)-1];
    logic [VW-1:0]  ref_vm  [0:(1<<NNW)-1];
    logic [VW-1:0]  ref_com [0:(1<<NNW)-1];

    logic           pre_we;
    logic [NNW-1:0] pre_addr;
    logic [VW-1:0]  pre_data;

    wr_t exp_q[$];
    bit  exp_sat;
    int  cyc;
    int  n_checks;
    int  n_errors;

    dendrite_acc #(.NNW(NNW), .WD(WD), .WW(WW), .VW(VW)) dut (
        .clk              (clk),
        .rst              (rst),
        .axon_sd_vld      (axon_sd_vld),
        .axon_sd_vm_addr  (axon_sd_vm_addr),
        .axon_sd_wgt_addr (axon_sd_wgt_addr),
        .sd_wgt_ren       (sd_wgt_ren),
        .sd_wgt_raddr     (sd_wgt_raddr),
        .sd_wgt_rdata     (sd_wgt_rdata),
        .sd_vm_ren        (sd_vm_ren),
        .sd_vm_raddr      (sd_vm_raddr),
        .sd_vm_rdata      (sd_vm_rdata),
        .sd_vm_we         (sd_vm_we),
        .sd_vm_waddr      (sd_vm_waddr),
        .sd_vm_wdata      (sd_vm_wdata),
        .sd_busy          (sd_busy),
        .sd_sat_flag      (sd_sat_flag)
    );

    // Clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memories: read data one cycle after enable, old data on same-cycle read/write
    always @(posedge clk) begin
        if (sd_vm_ren)  sd_vm_rdata  <= vm_mem[sd_vm_raddr];
        if (sd_wgt_ren) sd_wgt_rdata <= wgt_mem[sd_wgt_raddr];
        if (sd_vm_we)   vm_mem[sd_vm_waddr] <= sd_vm_wdata;
        if (pre_we)     vm_mem[pre_addr] <= pre_data;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h cycle=%0d", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard: every cycle, compare write port, busy and flag against expectations
    always @(negedge clk) begin
        wr_t e;
        if (pre_we) ref_com[pre_addr] = pre_data;
        if (rst) begin
            exp_q.delete();
            exp_sat = 1'b0;
        end else begin
            check("busy", 32'(sd_busy), 32'(exp_q.size() != 0));
            check("vm_ren", 32'(sd_vm_ren), 32'(axon_sd_vld));
            check("wgt_ren", 32'(sd_wgt_ren), 32'(axon_sd_vld));
            if (axon_sd_vld) begin
                check("vm_raddr", 32'(sd_vm_raddr), 32'(axon_sd_vm_addr));
                check("wgt_raddr", 32'(sd_wgt_raddr), 32'(axon_sd_wgt_addr));
            end
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("we", 32'(sd_vm_we), 32'd1);
                check("waddr", 32'(sd_vm_waddr), 32'(e.addr));
                check("wdata", 32'(sd_vm_wdata), 32'(e.data));
                if (e.sat) exp_sat = 1'b1;
                ref_com[e.addr] = e.data;
            end else begin
                check("we_idle", 32'(sd_vm_we), 32'd0);
            end
            check("sat_flag", 32'(sd_sat_flag), 32'(exp_sat));
        end
    end

    // Driver tasks
    task automatic cycle_op(input bit vld, input logic [NNW-1:0] va, input logic [WD-1:0] wa);
        int  v;
        bit  sat;
        @(posedge clk);
        #1;
        axon_sd_vld      = vld;
        axon_sd_vm_addr  = va;
        axon_sd_wgt_addr = wa;
        if (vld) begin
            v   = int'($signed(ref_vm[va])) + int'($signed(wgt_mem[wa]));
            sat = 1'b0;
`ifdef DENDRITE_SAT_EN
            if (v > VMAX) begin v = VMAX; sat = 1'b1; end
            if (v < VMIN) begin v = VMIN; sat = 1'b1; end
`endif
            ref_vm[va] = v[VW-1:0];
            exp_q.push_back('{addr: va, data: v[VW-1:0], sat: sat, cyc: cyc + 2});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_op(1'b0, '0, '0);
    endtask

    task automatic set_vm(input logic [NNW-1:0] a, input logic [VW-1:0] d);
        @(posedge clk);
        #1;
        axon_sd_vld = 1'b0;
        pre_we      = 1'b1;
        pre_addr    = a;
        pre_data    = d;
        ref_vm[a]   = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 32'(sd_vm_we), 32'd0);
        check({tag, "_waddr"}, 32'(sd_vm_waddr), 32'd0);
        check({tag, "_wdata"}, 32'(sd_vm_wdata), 32'd0);
        check({tag, "_busy"}, 32'(sd_busy), 32'd0);
        check({tag, "_sat"}, 32'(sd_sat_flag), 32'd0);
        check({tag, "_vm_ren"}, 32'(sd_vm_ren), 32'd0);
        check({tag, "_wgt_ren"}, 32'(sd_wgt_ren), 32'd0);
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        exp_sat          = 1'b0;
        rst              = 1'b1;
        axon_sd_vld      = 1'b0;
        axon_sd_vm_addr  = '0;
        axon_sd_wgt_addr = '0;
        pre_we           = 1'b0;
        pre_addr         = '0;
        pre_data         = '0;
        for (int i = 0; i < (1 << NNW); i++) begin
            vm_mem[i]  = '0;
            ref_vm[i]  = '0;
            ref_com[i] = '0;
        end
        for (int i = 0; i < (1 << WD); i++) wgt_mem[i] = WW'($urandom_range(0, 255));
        wgt_mem[1]  = 8'd1;
        wgt_mem[2]  = 8'd2;
        wgt_mem[3]  = 8'hF9;   // -7
        wgt_mem[4]  = 8'd3;
        wgt_mem[10] = 8'd5;
        wgt_mem[20] = 8'd20;

        @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single op: 100 + (-7)
        set_vm(12'd5, 16'd100);
        cycle_op(1'b1, 12'd5, 6'd3);
        idle(3);

        // A,A,A: WR forwarding
        set_vm(12'd9, 16'd0);
        cycle_op(1'b1, 12'd9, 6'd1);
        cycle_op(1'b1, 12'd9, 6'd2);
        cycle_op(1'b1, 12'd9, 6'd4);
        idle(3);

        // A,B,A: WB2 forwarding
        set_vm(12'd4, 16'd10);
        set_vm(12'd7, 16'd0);
        cycle_op(1'b1, 12'd4, 6'd10);
        cycle_op(1'b1, 12'd7, 6'd10);
        cycle_op(1'b1, 12'd4, 6'd10);
        idle(3);

        // Gap: second operand must come from memory
        set_vm(12'd2, 16'd0);
        cycle_op(1'b1, 12'd2, 6'd1);
        idle(2);
        cycle_op(1'b1, 12'd2, 6'd1);
        idle(3);

        // Overflow boundary: 32760 + 20
        set_vm(12'd1, 16'd32760);
        cycle_op(1'b1, 12'd1, 6'd20);
        idle(3);

        // Reset in the cycle after an op: the op is dropped
        set_vm(12'd5, 16'd100);
        cycle_op(1'b1, 12'd5, 6'd3);
        @(posedge clk);
        #1;
        axon_sd_vld = 1'b0;
        rst         = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        for (int i = 0; i < 4096; i++) ref_vm[i] = ref_com[i];
        @(posedge clk);
        #1;
        check_reset_outputs("rst_t2");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("dropped_op", 32'(vm_mem[5]), 32'd100);
        cycle_op(1'b1, 12'd5, 6'd3);
        idle(3);

        // Random traffic on a small address set to exercise forwarding and gaps
        for (int a = 0; a < 8; a++) set_vm(NNW'(a), VW'($urandom_range(0, 65535)));
        for (int i = 0; i < 400; i++) begin
            cycle_op($urandom_range(0, 3) != 0, NNW'($urandom_range(0, 7)), WD'($urandom_range(0, 63)));
        end
        idle(4);
        check("drain", 32'(exp_q.size()), 32'd0);
        for (int a = 0; a < 8; a++) check("final_vm", 32'(vm_mem[a]), 32'(ref_vm[a]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
